wishbone_arbiter: RTL

WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

---
 rtl/wishbone_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/wishbone_arbiter.sv
// Two-master Wishbone arbiter with round-robin tie break and a dead cycle on every handover.
// Optional stalled-strobe watchdog compiled in with WB_ARB_TIMEOUT_EN.
module wishbone_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic        m0_str_i,
  input  logic        m0_cyc_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  output logic        m0_ack_o,

  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic        m1_str_i,
  input  logic        m1_cyc_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  output logic        m1_ack_o,

  output logic [31:0] s_addr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  output logic        s_str_o,
  output logic        s_cyc_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  input  logic        s_ack_i,

  output logic [1:0]  grant,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_stateNext;
  logic   r_lastOwner;
  logic   w_toExpire;

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] r_toCount;
  logic        w_stall;

  assign w_stall    = (r_state != IDLE) && s_str_o && !s_ack_i;
  assign w_toExpire = (r_state != IDLE) && (r_toCount == TIMEOUT_CYCLES);

  // Counts consecutive stalled strobe cycles of the current owner
  always_ff @(posedge clk) begin
    if (rst) begin
      r_toCount <= 16'd0;
    end else if (w_toExpire || !w_stall) begin
      r_toCount <= 16'd0;
    end else begin
      r_toCount <= r_toCount + 16'd1;
    end
  end

  assign timeout = w_toExpire;
`else
  assign w_toExpire = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lastOwner <= 1'b1;
    end else begin
      r_state <= w_stateNext;
      if (r_state == IDLE && w_stateNext == GRANT0) begin
        r_lastOwner <= 1'b0;
      end else if (r_state == IDLE && w_stateNext == GRANT1) begin
        r_lastOwner <= 1'b1;
      end
    end
  end

  // Grants are only issued from IDLE, so every handover costs one dead cycle
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_stateNext = r_lastOwner ? GRANT0 : GRANT1;
        end else if (m0_cyc_i) begin
          w_stateNext = GRANT0;
        end else if (m1_cyc_i) begin
          w_stateNext = GRANT1;
        end
      end
      GRANT0: begin
        if (!m0_cyc_i || w_toExpire) begin
          w_stateNext = IDLE;
        end
      end
      GRANT1: begin
        if (!m1_cyc_i || w_toExpire) begin
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    s_addr_o = 32'd0;
    s_dat_o  = 32'd0;
    s_str_o  = 1'b0;
    s_cyc_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = 4'd0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    grant    = 2'b00;
    case (r_state)
      GRANT0: begin
        s_addr_o = m0_addr_i;
        s_dat_o  = m0_dat_i;
        s_str_o  = m0_str_i;
        s_cyc_o  = m0_cyc_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        m0_ack_o = s_ack_i;
        grant    = 2'b01;
      end
      GRANT1: begin
        s_addr_o = m1_addr_i;
        s_dat_o  = m1_dat_i;
        s_str_o  = m1_str_i;
        s_cyc_o  = m1_cyc_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i;
        grant    = 2'b10;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule
